// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature alarm controller.
package temp_pkg;

    // FSM state encoding; the values are visible on the estado output.
    typedef enum logic [1:0] {
        StNormal   = 2'b00,
        StSospecha = 2'b01,
        StAlarma   = 2'b10,
        StRecupera = 2'b11
    } estado_t;

    // Cause codes reported on tipo.
    localparam logic [1:0] TIPO_NINGUNO = 2'b00;
    localparam logic [1:0] TIPO_FRIO    = 2'b01;
    localparam logic [1:0] TIPO_CALOR   = 2'b10;

    // Default normal-range limits, degrees C scaled x10.
    localparam int TEMP_FRIO_DEF = 180;
    localparam int TEMP_ALTO_DEF = 250;

    localparam int TEMP_W = 11;

endpackage

// File: rtl/comparador_temp.sv
// Combinational range test of one signed temperature sample.
module comparador_temp
    import temp_pkg::*;
#(
    parameter int TEMP_FRIO = TEMP_FRIO_DEF,
    parameter int TEMP_ALTO = TEMP_ALTO_DEF
) (
    input  logic signed [TEMP_W-1:0] temp,
    output logic                     fuera_rango,
    output logic                     es_frio
);

    localparam logic signed [TEMP_W-1:0] LIM_FRIO = TEMP_W'(TEMP_FRIO);
    localparam logic signed [TEMP_W-1:0] LIM_ALTO = TEMP_W'(TEMP_ALTO);

    logic es_calor;

    // Limits themselves count as in range.
    always_comb begin
        es_frio     = (temp < LIM_FRIO);
        es_calor    = (temp > LIM_ALTO);
        fuera_rango = es_frio | es_calor;
    end

endmodule

// File: rtl/control_alarma_temp.sv
// Temperature alarm controller: confirms N_CONFIRM consecutive out-of-range
// samples before alarming and N_NORMAL consecutive in-range samples to clear.
module control_alarma_temp
    import temp_pkg::*;
#(
    parameter int TEMP_FRIO = TEMP_FRIO_DEF,
    parameter int TEMP_ALTO = TEMP_ALTO_DEF,
    parameter int N_CONFIRM = 4,
    parameter int N_NORMAL  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     muestra_valida,
    input  logic signed [TEMP_W-1:0] temp_in,
    input  logic                     ack,
    output logic signed [TEMP_W-1:0] temp_reg,
    output logic                     alarma,
    output logic                     alarma_pend,
    output logic [1:0]               tipo,
    output logic [1:0]               estado
);

    localparam logic [2:0] N_CONF_C = 3'(N_CONFIRM);
    localparam logic [2:0] N_NORM_C = 3'(N_NORMAL);

    estado_t                   state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic signed [TEMP_W-1:0]  temp_q, temp_d;
    logic [1:0]                tipo_q, tipo_d;
    logic                      pend_q, pend_d;
    logic                      fuera;
    logic                      es_frio;
    logic                      entrada;

    comparador_temp #(
        .TEMP_FRIO (TEMP_FRIO),
        .TEMP_ALTO (TEMP_ALTO)
    ) u_comparador (
        .temp        (temp_in),
        .fuera_rango (fuera),
        .es_frio     (es_frio)
    );

    // Next-state, counter, cause and pending-flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        tipo_d  = tipo_q;
        entrada = 1'b0;

        if (muestra_valida) begin
            temp_d = temp_in;
            unique case (state_q)
                StNormal: begin
                    if (fuera) begin
                        if (N_CONF_C == 3'd1) begin
                            state_d = StAlarma;
                            cnt_d   = 3'd0;
                            entrada = 1'b1;
                        end else begin
                            state_d = StSospecha;
                            cnt_d   = 3'd1;
                        end
                    end else begin
                        cnt_d = 3'd0;
                    end
                end
                StSospecha: begin
                    if (fuera) begin
                        if (cnt_q + 3'd1 == N_CONF_C) begin
                            state_d = StAlarma;
                            cnt_d   = 3'd0;
                            entrada = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = StNormal;
                        cnt_d   = 3'd0;
                    end
                end
                StAlarma: begin
                    if (!fuera) begin
                        if (N_NORM_C == 3'd1) begin
                            state_d = StNormal;
                            cnt_d   = 3'd0;
                            tipo_d  = TIPO_NINGUNO;
                        end else begin
                            state_d = StRecupera;
                            cnt_d   = 3'd1;
                        end
                    end
                end
                StRecupera: begin
                    if (!fuera) begin
                        if (cnt_q + 3'd1 == N_NORM_C) begin
                            state_d = StNormal;
                            cnt_d   = 3'd0;
                            tipo_d  = TIPO_NINGUNO;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        // Re-entry keeps the original cause and does not re-raise pend.
                        state_d = StAlarma;
                        cnt_d   = 3'd0;
                    end
                end
                default: begin
                    state_d = StNormal;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        if (entrada) begin
            tipo_d = es_frio ? TIPO_FRIO : TIPO_CALOR;
        end

        // A new alarm event wins over a simultaneous acknowledge.
        pend_d = entrada | (pend_q & ~ack);
    end

    // All state in one register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StNormal;
            cnt_q   <= 3'd0;
            temp_q  <= '0;
            tipo_q  <= TIPO_NINGUNO;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            tipo_q  <= tipo_d;
            pend_q  <= pend_d;
        end
    end

    // ALARMA and RECUPERA share the high state bit.
    always_comb begin
        temp_reg    = temp_q;
        alarma      = state_q[1];
        alarma_pend = pend_q;
        tipo        = tipo_q;
        estado      = state_q;
    end

endmodule
